// File: rtl/sync_ram_pkg.sv
// rtl/sync_ram_pkg.sv - shared state type and latency constants for sync_ram
package sync_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

endpackage

// File: rtl/sync_ram_rd_pipe.sv
// rtl/sync_ram_rd_pipe.sv - read response delay line (valid/data/err)
module sync_ram_rd_pipe #(
    parameter int DWIDTH  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_err
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;
    logic [DWIDTH-1:0]  data_q [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    // Data is not reset; the output gate below keeps it invisible until valid.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = valid_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    assign out_err   = valid_q[LATENCY-1] & err_q[LATENCY-1];

endmodule

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - single-port byte-enabled RAM with clear-on-reset and pipelined reads
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int AWIDTH         = 8,
    parameter int DWIDTH         = 32,
    parameter int DEPTH          = 2**AWIDTH,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [AWIDTH-1:0]   req_addr,
    input  logic [DWIDTH-1:0]   req_wdata,
    input  logic [DWIDTH/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DWIDTH-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int NBYTES = DWIDTH / 8;
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0]   LAST_ADDR = IW'(DEPTH - 1);
    localparam logic [AWIDTH:0] DEPTH_W   = (AWIDTH + 1)'(DEPTH);
    localparam ram_state_t      RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    if (RD_LATENCY != RD_LATENCY_MIN && RD_LATENCY != RD_LATENCY_MAX) begin : g_bad_latency
        $error("sync_ram: RD_LATENCY must be 1 or 2");
    end
    if ((DWIDTH % 8) != 0 || DWIDTH == 0) begin : g_bad_dwidth
        $error("sync_ram: DWIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH == 0 || DEPTH > (1 << AWIDTH)) begin : g_bad_depth
        $error("sync_ram: DEPTH must be in 1..2**AWIDTH");
    end

    ram_state_t        state_q, state_d;
    logic [IW-1:0]     clr_addr_q, clr_addr_d;
    logic              ready_q, ready_d;
    logic              clear_we;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic              accept;
    logic              in_range;
    logic              rd_fire;
    logic [IW-1:0]     idx;
    logic [DWIDTH-1:0] rd_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    // ready is registered from the next state so it never sees req_valid.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clear_we   = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_we = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = READY;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: ;
        endcase
        ready_d = (state_d == READY);
    end

    assign req_ready = ready_q;
    assign init_done = ready_q;
    assign accept    = req_valid && ready_q;
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);
    assign idx       = req_addr[IW-1:0];
    assign rd_word   = in_range ? mem[idx] : '0;
    assign rd_fire   = accept && !req_we;

    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_addr_q] <= '0;
        end else if (accept && req_we && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (req_be[i]) begin
                    mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    sync_ram_rd_pipe #(
        .DWIDTH  (DWIDTH),
        .LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_fire),
        .in_data   (rd_fire ? rd_word : '0),
        .in_err    (rd_fire && !in_range),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata),
        .out_err   (rsp_err)
    );

endmodule

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 SHALL have parameter AWIDTH, default 8: address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 32: data width in bits, a multiple of 8.
REQ-003 SHALL have parameter DEPTH, default 2**AWIDTH: number of implemented words, 1..2**AWIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: when 1, zero-fill all words after reset.
REQ-006 SHALL have one clock; reset is asynchronous and active-high.
REQ-007 Port clk, input, 1 bit: sole clock, rising edge.
REQ-008 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port req_valid, input, 1 bit: request present.
REQ-010 Port req_ready, output, 1 bit: request can be accepted.
REQ-011 Port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-012 Port req_addr, input, AWIDTH bits: word address.
REQ-013 Port req_wdata, input, DWIDTH bits: write data.
REQ-014 Port req_be, input, DWIDTH/8 bits: byte-lane write enables.
REQ-015 Port rsp_valid, output, 1 bit: read response valid for one cycle.
REQ-016 Port rsp_rdata, output, DWIDTH bits: read data.
REQ-017 Port rsp_err, output, 1 bit: the response is for an out-of-range address.
REQ-018 Port init_done, output, 1 bit: the clear sequence has completed.

Function
REQ-019 SHALL accept a request on a rising edge where req_valid && req_ready; one request at most per cycle.
REQ-020 SHALL implement FSM states CLEAR and READY.
- From reset: enter CLEAR if CLEAR_ON_RESET=1, otherwise READY.
- CLEAR: req_ready=0; write 0 to address 0..DEPTH-1, one word per cycle, ascending.
- CLEAR to READY: on the cycle after the DEPTH-1 write.
REQ-021 SHALL hold req_ready=1 and init_done=1 in READY; both SHALL be 0 in CLEAR.
REQ-022 An accepted write SHALL update only the byte lanes with req_be[i]=1, at the accepting edge.
- req_be=0 SHALL leave the word unchanged.
- Writes never produce a response.
REQ-023 An accepted read SHALL assert rsp_valid for exactly one cycle, RD_LATENCY cycles after the accepting edge.
- rsp_rdata is valid in that same cycle.
- Responses have no backpressure.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the post-write data.
REQ-025 Back-to-back reads SHALL sustain one response per cycle, in request order.
REQ-026 Addresses >= DEPTH:
- Writes SHALL be ignored.
- Reads SHALL respond with rsp_rdata=0 and rsp_err=1 at normal latency.
REQ-027 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-028 req_ready SHALL NOT depend combinationally on req_valid.

Reset
REQ-029 While reset=1:
- req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
- FSM in CLEAR (or READY if CLEAR_ON_RESET=0).
REQ-030 Reset asserted mid-CLEAR SHALL restart the clear from address 0 after deassertion.
REQ-031 Reset asserted with reads in flight SHALL discard them; no rsp_valid for them after deassertion.
REQ-032 With CLEAR_ON_RESET=0, storage contents SHALL be unaffected by reset.
- req_ready SHALL rise on the first edge after deassertion.

Structure
REQ-033 Package sync_ram_pkg SHALL hold:
- the FSM state typedef (CLEAR, READY);
- constants for legal RD_LATENCY values.
REQ-034 SHALL instantiate one sub-module, sync_ram_rd_pipe:
- a RD_LATENCY-deep valid/data/err shift register;
- async reset clears only the valid and err bits.
REQ-035 SHALL reject illegal parameters at elaboration:
- RD_LATENCY not 1 or 2;
- DWIDTH not a multiple of 8;
- DEPTH = 0 or DEPTH > 2**AWIDTH.

Verification
REQ-036 DEPTH=16, CLEAR_ON_RESET=1: release reset -> req_ready rises after exactly 16 cycles; a read of every address returns 0.
REQ-037 Sequence:
- write 0xDEADBEEF to address 3, be=0xF;
- write 0x000000AA, be=0x1;
- read address 3 -> 0xDEADBEAA, with rsp_valid exactly RD_LATENCY cycles after acceptance (check 1 and 2).
REQ-038 Eight back-to-back reads of addresses 0..7 (pre-written with value = addr) -> 8 consecutive rsp_valid cycles with data 0..7 in order.
REQ-039 DEPTH=12, AWIDTH=4: write 0x55 to address 13, then read 13 -> rsp_rdata=0, rsp_err=1; read address 11 -> rsp_err=0.
REQ-040 Reset pulse at clear address 5, and separately with a read in flight:
- clear restarts at 0 and takes the full DEPTH cycles;
- the in-flight read produces no response.
